// File: rtl/uram_readout_scheduler_if.sv
// Handshake bundle between the event buffers, the readout state machine,
// the firmware loader and the readout scheduler.
//   slave  : the scheduler (consumes flags, drives pointers and grants)
//   master : the surrounding logic (drives flags, observes pointers and grants)
interface uram_readout_scheduler_if #(
    parameter int unsigned BUF_BITS = 2
) ();
    logic                clk_ce_i;
    logic                write_done_i;
    logic [BUF_BITS-1:0] write_buf_o;
    logic                full_o;
    logic [BUF_BITS:0]   occupancy_o;
    logic [BUF_BITS-1:0] read_buf_o;
    logic                data_available_o;
    logic                complete_i;
    logic                valid_i;
    logic                fw_req_i;
    logic                fw_loading_o;
    logic                fw_done_i;
    logic [15:0]         dropped_o;

    modport slave (
        input  clk_ce_i, write_done_i, complete_i, valid_i, fw_req_i, fw_done_i,
        output write_buf_o, full_o, occupancy_o, read_buf_o, data_available_o,
               fw_loading_o, dropped_o
    );

    modport master (
        output clk_ce_i, write_done_i, complete_i, valid_i, fw_req_i, fw_done_i,
        input  write_buf_o, full_o, occupancy_o, read_buf_o, data_available_o,
               fw_loading_o, dropped_o
    );
endinterface

// File: rtl/uram_readout_scheduler.sv
// URAM event readout scheduler: tracks filled event buffers, offers them one
// at a time to the readout state machine, and arbitrates the shared readout
// path against firmware loading with a bounded starvation window.
// Ports:
//   clk_i, rstb_i : clock, asynchronous active-low reset
//   bus (slave)   : write_done_i/write_buf_o/full_o/occupancy_o/dropped_o on
//                   the write side; read_buf_o/data_available_o/complete_i/
//                   valid_i/clk_ce_i toward the readout SM; fw_req_i/
//                   fw_loading_o/fw_done_i toward the firmware loader.
//   All outputs are direct register outputs.
module uram_readout_scheduler #(
    parameter int unsigned NBUF      = 4,
    parameter int unsigned BUF_BITS  = 2,
    parameter int unsigned FW_STARVE = 64
) (
    input  logic                   clk_i,
    input  logic                   rstb_i,
    uram_readout_scheduler_if.slave bus
);
    localparam int unsigned OCC_W    = BUF_BITS + 1;
    localparam int unsigned STARVE_W = 8;
    localparam int unsigned DROP_W   = 16;
    localparam logic [OCC_W-1:0]    OCC_FULL   = OCC_W'(NBUF);
    localparam logic [OCC_W-1:0]    OCC_ONE    = OCC_W'(1);
    localparam logic [BUF_BITS-1:0] PTR_ONE    = BUF_BITS'(1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(FW_STARVE);
    localparam logic [DROP_W-1:0]   DROP_MAX   = '1;

    typedef enum logic [2:0] {IDLE, READ, DRAIN, FW_GRANT, FW_EXIT} state_t;

    state_t              state_q;
    logic [BUF_BITS-1:0] write_buf_q;
    logic [BUF_BITS-1:0] read_buf_q;
    logic [OCC_W-1:0]    occ_q;
    logic [OCC_W-1:0]    occ_nxt;
    logic                full_q;
    logic                da_q;
    logic                fw_q;
    logic [DROP_W-1:0]   dropped_q;
    logic [STARVE_W-1:0] starve_q;
    logic                ce_seen_q;
    logic                proto_err_q;

    logic retire;
    logic wr_accept;
    logic drop;
    logic fw_priority;

    // A retire in the same cycle frees a buffer, so a write is accepted even when full.
    assign retire      = bus.complete_i && (state_q == READ);
    assign wr_accept   = bus.write_done_i && (!full_q || retire);
    assign drop        = bus.write_done_i && !wr_accept;
    assign fw_priority = (starve_q == STARVE_MAX);

    // Occupancy next value; simultaneous accept and retire cancel.
    always_comb begin
        occ_nxt = occ_q;
        if (wr_accept && !retire) begin
            occ_nxt = occ_q + OCC_ONE;
        end else if (!wr_accept && retire) begin
            occ_nxt = occ_q - OCC_ONE;
        end
    end

    // Buffer pointers, occupancy, full flag and drop counter.
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            write_buf_q <= '0;
            read_buf_q  <= '0;
            occ_q       <= '0;
            full_q      <= 1'b0;
            dropped_q   <= '0;
        end else begin
            if (wr_accept) write_buf_q <= write_buf_q + PTR_ONE;
            if (retire)    read_buf_q  <= read_buf_q + PTR_ONE;
            occ_q  <= occ_nxt;
            full_q <= (occ_nxt == OCC_FULL);
            if (drop && (dropped_q != DROP_MAX)) dropped_q <= dropped_q + DROP_W'(1);
        end
    end

    // Cycles firmware has waited without a grant, saturating.
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            starve_q <= '0;
        end else if (bus.fw_req_i && !fw_q) begin
            if (!fw_priority) starve_q <= starve_q + STARVE_W'(1);
        end else begin
            starve_q <= '0;
        end
    end

    // Readout / firmware arbitration FSM with registered grants.
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            state_q   <= IDLE;
            da_q      <= 1'b0;
            fw_q      <= 1'b0;
            ce_seen_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.fw_req_i && ((occ_q == '0) || fw_priority)) begin
                        state_q <= FW_GRANT;
                        fw_q    <= 1'b1;
                    end else if ((occ_q != '0) && !bus.valid_i) begin
                        state_q <= READ;
                        da_q    <= 1'b1;
                    end
                end
                READ: begin
                    if (bus.complete_i) begin
                        state_q   <= DRAIN;
                        da_q      <= 1'b0;
                        ce_seen_q <= 1'b0;
                    end
                end
                // Guarantees the SM samples data_available low on at least one ce.
                DRAIN: begin
                    if (bus.clk_ce_i) ce_seen_q <= 1'b1;
                    if ((ce_seen_q || bus.clk_ce_i) && !bus.valid_i) state_q <= IDLE;
                end
                FW_GRANT: begin
                    if (bus.fw_done_i || !bus.fw_req_i) begin
                        state_q <= FW_EXIT;
                        fw_q    <= 1'b0;
                    end
                end
                // SM needs one ce with fw_loading low to return to HEADER0.
                FW_EXIT: begin
                    if (bus.clk_ce_i) state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    da_q    <= 1'b0;
                    fw_q    <= 1'b0;
                end
            endcase
        end
    end

    // Sticky record of a complete flag arriving outside READ.
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            proto_err_q <= 1'b0;
        end else if (bus.complete_i && (state_q != READ)) begin
            proto_err_q <= 1'b1;
        end
    end

    a_grant_exclusive: assert property (@(posedge clk_i) disable iff (!rstb_i) !(da_q && fw_q));
    a_no_proto_err:    assert property (@(posedge clk_i) disable iff (!rstb_i) !proto_err_q);

    assign bus.write_buf_o      = write_buf_q;
    assign bus.read_buf_o       = read_buf_q;
    assign bus.occupancy_o      = occ_q;
    assign bus.full_o           = full_q;
    assign bus.data_available_o = da_q;
    assign bus.fw_loading_o     = fw_q;
    assign bus.dropped_o        = dropped_q;
endmodule
